// File: rtl/auth_msg_arbiter_pkg.sv
// Shared constants and state encoding for the authentication message arbiter
// and its round-robin picker.
package auth_msg_arbiter_pkg;

    localparam int NUM_REQ         = 3;
    localparam int HDR_LEN         = 32;
    localparam int PAY_LEN         = 480;
    localparam int MSG_LEN         = 512;
    localparam int IDX_W           = 2;
    localparam int TIMER_W         = 16;
    localparam int DEFAULT_TIMEOUT = 1000;

    localparam logic [IDX_W-1:0] REQ_DIGESTS = 2'd0;
    localparam logic [IDX_W-1:0] REQ_CERT    = 2'd1;
    localparam logic [IDX_W-1:0] REQ_CHAL    = 2'd2;

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        SEND      = 4'b0010,
        WAIT_RESP = 4'b0100,
        RELEASE   = 4'b1000
    } arb_state_e;

endpackage

// File: rtl/auth_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NREQ.
module auth_rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int               c;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output and temporary gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        found = 1'b0;
        idx   = '0;
        c     = 0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            cand = IDX_W'(c);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/auth_msg_arbiter.sv
// Round-robin owner of the outbound authentication message path: grants one
// requester, holds it until its response returns or times out, then releases.
module auth_msg_arbiter
    import auth_msg_arbiter_pkg::*;
#(
    parameter int NREQ    = NUM_REQ,
    parameter int HDR_W   = HDR_LEN,
    parameter int PAY_W   = PAY_LEN,
    parameter int MSG_W   = MSG_LEN,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  abort,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*HDR_W-1:0] req_header,
    input  logic [NREQ*PAY_W-1:0] req_payload,
    output logic [NREQ-1:0]       req_ack,
    output logic                  tx_valid,
    output logic [HDR_W-1:0]      tx_header,
    output logic [PAY_W-1:0]      tx_payload,
    input  logic                  tx_ack,
    input  logic                  rx_valid,
    input  logic [MSG_W-1:0]      rx_msg,
    output logic [NREQ-1:0]       resp_valid,
    output logic [MSG_W-1:0]      resp_msg,
    output logic [NREQ-1:0]       timeout_err,
    output logic [IDX_W-1:0]      grant_id,
    output logic                  busy,
    output logic [7:0]            stray_rx_cnt
);

    arb_state_e          state, state_d;
    logic [IDX_W-1:0]    pointer, pointer_d, grant_id_d;
    logic [TIMER_W-1:0]  timer, timer_d;
    logic [NREQ-1:0]     req_ack_d, resp_valid_d, timeout_err_d;
    logic                tx_valid_d, busy_d;
    logic [HDR_W-1:0]    tx_header_d, hdr_sel;
    logic [PAY_W-1:0]    tx_payload_d, pay_sel;
    logic [MSG_W-1:0]    resp_msg_d;
    logic [7:0]          stray_d, stray_inc;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

    auth_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req   (req_valid),
        .ptr   (pointer),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        hdr_sel = '0;
        pay_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                hdr_sel = req_header[i*HDR_W +: HDR_W];
                pay_sel = req_payload[i*PAY_W +: PAY_W];
            end
        end
    end

    // Responses arriving while no one is waiting are dropped but counted.
    assign stray_inc = (rx_valid && stray_rx_cnt != 8'hFF) ? stray_rx_cnt + 8'd1 : stray_rx_cnt;

    always_comb begin
        state_d       = state;
        pointer_d     = pointer;
        grant_id_d    = grant_id;
        timer_d       = timer;
        tx_valid_d    = tx_valid;
        tx_header_d   = tx_header;
        tx_payload_d  = tx_payload;
        busy_d        = busy;
        resp_msg_d    = resp_msg;
        stray_d       = stray_rx_cnt;
        req_ack_d     = '0;
        resp_valid_d  = '0;
        timeout_err_d = '0;

        if (abort) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            timer_d    = '0;
        end else begin
            case (state)
                IDLE: begin
                    stray_d = stray_inc;
                    if (pick_found) begin
                        grant_id_d   = pick_idx;
                        tx_header_d  = hdr_sel;
                        tx_payload_d = pay_sel;
                        tx_valid_d   = 1'b1;
                        busy_d       = 1'b1;
                        state_d      = SEND;
                    end
                end
                SEND: begin
                    stray_d = stray_inc;
                    if (tx_ack) begin
                        tx_valid_d          = 1'b0;
                        req_ack_d[grant_id] = 1'b1;
                        timer_d             = '0;
                        state_d             = WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    timer_d = timer + TIMER_W'(1);
                    if (rx_valid) begin
                        resp_msg_d             = rx_msg;
                        resp_valid_d[grant_id] = 1'b1;
                        state_d                = RELEASE;
                    end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                        timeout_err_d[grant_id] = 1'b1;
                        state_d                 = RELEASE;
                    end
                end
                RELEASE: begin
                    stray_d   = stray_inc;
                    pointer_d = (grant_id == IDX_W'(NREQ - 1)) ? '0 : grant_id + IDX_W'(1);
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pointer      <= '0;
            grant_id     <= '0;
            timer        <= '0;
            tx_valid     <= 1'b0;
            tx_header    <= '0;
            tx_payload   <= '0;
            busy         <= 1'b0;
            resp_msg     <= '0;
            stray_rx_cnt <= '0;
            req_ack      <= '0;
            resp_valid   <= '0;
            timeout_err  <= '0;
        end else begin
            state        <= state_d;
            pointer      <= pointer_d;
            grant_id     <= grant_id_d;
            timer        <= timer_d;
            tx_valid     <= tx_valid_d;
            tx_header    <= tx_header_d;
            tx_payload   <= tx_payload_d;
            busy         <= busy_d;
            resp_msg     <= resp_msg_d;
            stray_rx_cnt <= stray_d;
            req_ack      <= req_ack_d;
            resp_valid   <= resp_valid_d;
            timeout_err  <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_auth_msg_arbiter.sv
// Directed bench for auth_msg_arbiter: a transaction table plus hand-written
// stray, abort and asynchronous-reset sequences.
module tb_auth_msg_arbiter;
    import auth_msg_arbiter_pkg::*;

    localparam int TO = 8;

    logic             clk, reset, abort, tx_ack, rx_valid;
    logic [2:0]       req_valid;
    logic [95:0]      req_header;
    logic [1439:0]    req_payload;
    logic [511:0]     rx_msg;
    logic [2:0]       req_ack, resp_valid, timeout_err;
    logic             tx_valid, busy;
    logic [31:0]      tx_header;
    logic [479:0]     tx_payload;
    logic [511:0]     resp_msg;
    logic [1:0]       grant_id;
    logic [7:0]       stray_rx_cnt;

    auth_msg_arbiter #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .abort        (abort),
        .req_valid    (req_valid),
        .req_header   (req_header),
        .req_payload  (req_payload),
        .req_ack      (req_ack),
        .tx_valid     (tx_valid),
        .tx_header    (tx_header),
        .tx_payload   (tx_payload),
        .tx_ack       (tx_ack),
        .rx_valid     (rx_valid),
        .rx_msg       (rx_msg),
        .resp_valid   (resp_valid),
        .resp_msg     (resp_msg),
        .timeout_err  (timeout_err),
        .grant_id     (grant_id),
        .busy         (busy),
        .stray_rx_cnt (stray_rx_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] add;        // request bits raised at the start of the transaction
        logic [1:0] exp_grant;  // hand-computed round-robin winner
        int         ack_dly;    // SEND cycles before tx_ack
        int         rx_dly;     // WAIT_RESP cycle carrying rx_valid; 0 = never
    } txn_t;

    txn_t       vecs [9];
    int         n_vec, n_bad;
    logic [2:0] pending;

    function automatic logic [31:0] hdr(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    function automatic logic [479:0] pay(input int i);
        return {15{32'h5A00_0000 + 32'(i)}};
    endfunction

    function automatic logic [511:0] resp_pat(input int k);
        return {16{32'hC0DE_0000 + 32'(k)}};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input txn_t t);
        pending   = pending | t.add;
        req_valid = pending;
        tick();
        check("grant_tx_valid", tx_valid, 1);
        check("grant_id", grant_id, t.exp_grant);
        check("tx_header", tx_header, hdr(t.exp_grant));
        check("tx_payload", tx_payload, pay(t.exp_grant));
        check("busy_send", busy, 1);
        for (int k = 0; k < t.ack_dly; k++) begin
            tick();
            check("send_hold", tx_valid, 1);
            check("send_no_ack", req_ack, 0);
        end
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        check("req_ack", req_ack, 3'b001 << t.exp_grant);
        check("tx_valid_drop", tx_valid, 0);
        pending[t.exp_grant] = 1'b0;
        req_valid = pending;
        for (int k = 1; k <= TO; k++) begin
            if (k == t.rx_dly) begin
                rx_valid = 1'b1;
                rx_msg   = resp_pat(k);
            end
            tick();
            rx_valid = 1'b0;
            if (k == 1) check("req_ack_pulse", req_ack, 0);
            if (k == t.rx_dly) begin
                check("resp_valid", resp_valid, 3'b001 << t.exp_grant);
                check("resp_msg", resp_msg, resp_pat(k));
                check("no_timeout", timeout_err, 0);
                break;
            end else if (k == TO) begin
                check("timeout_err", timeout_err, 3'b001 << t.exp_grant);
                check("timeout_no_resp", resp_valid, 0);
                break;
            end else begin
                check("wait_quiet", {resp_valid, timeout_err}, 0);
            end
        end
        tick();
        check("release_busy", busy, 0);
        check("release_pulses", {resp_valid, timeout_err}, 0);
    endtask

    initial begin
        n_vec = 0; n_bad = 0; pending = '0;
        reset = 1'b1; abort = 1'b0; tx_ack = 1'b0; rx_valid = 1'b0;
        req_valid = '0; rx_msg = '0;
        for (int i = 0; i < 3; i++) begin
            req_header[i*32 +: 32]   = hdr(i);
            req_payload[i*480 +: 480] = pay(i);
        end

        vecs[0] = '{3'b010, 2'd1, 3, 6};   // single request, header A5A5_0001
        vecs[1] = '{3'b001, 2'd0, 0, 0};   // pointer 2 wraps to 0; timeout
        vecs[2] = '{3'b101, 2'd2, 1, TO};  // rx_valid coincides with timeout
        vecs[3] = '{3'b110, 2'd0, 0, 1};   // round robin: 0,1,2,0 with all asserted
        vecs[4] = '{3'b001, 2'd1, 0, 2};
        vecs[5] = '{3'b000, 2'd2, 0, 3};
        vecs[6] = '{3'b110, 2'd0, 0, 1};
        vecs[7] = '{3'b000, 2'd1, 2, 4};
        vecs[8] = '{3'b000, 2'd2, 0, 5};

        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {req_ack, resp_valid, timeout_err}, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_stray", stray_rx_cnt, 0);
        check("rst_resp_msg", resp_msg, 0);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Stray responses in IDLE saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            rx_valid = 1'b1;
            rx_msg   = resp_pat(99);
            tick();
            rx_valid = 1'b0;
            tick();
            if (i == 9) check("stray_10", stray_rx_cnt, 10);
        end
        check("stray_sat", stray_rx_cnt, 255);
        check("stray_no_resp", resp_valid, 0);

        // Abort in SEND beats a simultaneous tx_ack; pointer stays at 0.
        pending   = 3'b110;
        req_valid = pending;
        tick();
        check("abort_pre_grant", grant_id, 1);
        abort  = 1'b1;
        tx_ack = 1'b1;
        tick();
        abort  = 1'b0;
        tx_ack = 1'b0;
        check("abort_tx_valid", tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_no_ack", req_ack, 0);
        tick();
        check("abort_regrant", grant_id, 1);
        check("abort_regrant_valid", tx_valid, 1);

        // Latched message stays stable when the request side changes.
        req_header[32 +: 32] = 32'hDEAD_BEEF;
        pending   = '0;
        req_valid = pending;
        tick();
        check("send_stable", tx_header, hdr(1));
        req_header[32 +: 32] = hdr(1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        check("req_ack_1", req_ack, 3'b010);

        // Asynchronous reset between edges in WAIT_RESP.
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_grant_id", grant_id, 0);
        check("arst_tx_header", tx_header, 0);
        check("arst_tx_payload", tx_payload, 0);
        check("arst_stray", stray_rx_cnt, 0);
        check("arst_resp_msg", resp_msg, 0);
        #2;
        reset = 1'b0;
        tick();
        check("post_rst_idle", {busy, tx_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
